dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_pkg.sv | 14 +
 rtl/rr_arb2.sv | 25 ++
 rtl/dmem_arbiter.sv | 109 ++++++++++
 tb/tb_dmem_arbiter.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types for the data-memory arbiter: FSM state encoding and requester indices.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } state_t;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter: one-hot grant, pointer remembers the last winner.
module rr_arb2
  import dmem_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] req,
  input  logic       update,
  output logic [1:0] gnt
);

  logic last;

  // On a tie the requester that did not win last time goes first.
  always_comb begin
    gnt = req;
    if (req == 2'b11) gnt = (last == REQ1) ? 2'b01 : 2'b10;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) last <= REQ1;
    else if (update && (req != 2'b00)) last <= gnt[1];
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one data-memory port between the processor data port (0) and the loader (1).
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int READ_LAT = 1,
  parameter int AW       = 32
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          req0,
  input  logic          we0,
  input  logic [AW-1:0] addr0,
  input  logic [31:0]   wdata0,
  input  logic          req1,
  input  logic          we1,
  input  logic [AW-1:0] addr1,
  input  logic [31:0]   wdata1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          rvalid0,
  output logic          rvalid1,
  output logic [31:0]   rdata0,
  output logic [31:0]   rdata1,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata
);

  localparam logic [1:0] LAT_INIT = 2'(READ_LAT - 1);

  state_t     state, state_nxt;
  logic       owner;
  logic [1:0] cnt;
  logic [1:0] arb_gnt;
  logic       take;
  logic       win;

  // Grants are only issued while idle and out of reset, so reset forces gnt low.
  assign take = reset_n && (state == IDLE) && (req0 || req1);
  assign win  = arb_gnt[1];

  rr_arb2 u_arb (
    .clk     (clk),
    .reset_n (reset_n),
    .req     ({req1, req0}),
    .update  (take),
    .gnt     (arb_gnt)
  );

  assign gnt0    = take && !win;
  assign gnt1    = take && win;
  assign rvalid0 = (state == RESP) && (owner == REQ0);
  assign rvalid1 = (state == RESP) && (owner == REQ1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (take) state_nxt = ACCESS;
      ACCESS:  state_nxt = mem_we ? IDLE : WAIT;
      WAIT:    if (cnt == 2'd0) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
    endcase
  end

  // The memory-side registers double as the captured request: they are loaded
  // on the grant edge, so mem_en/mem_we are high for exactly the ACCESS cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      owner     <= REQ0;
      cnt       <= 2'd0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      rdata0    <= '0;
      rdata1    <= '0;
    end else begin
      mem_en <= 1'b0;
      mem_we <= 1'b0;
      case (state)
        IDLE: begin
          if (take) begin
            owner     <= win;
            mem_en    <= 1'b1;
            mem_we    <= win ? we1 : we0;
            mem_addr  <= win ? addr1 : addr0;
            mem_wdata <= win ? wdata1 : wdata0;
          end
        end
        ACCESS: cnt <= LAT_INIT;
        WAIT: begin
          if (cnt != 2'd0)     cnt    <= cnt - 2'd1;
          else if (owner == REQ1) rdata1 <= mem_rdata;
          else                 rdata0 <= mem_rdata;
        end
        RESP: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: four instances (READ_LAT 1..4), each with its own memory model.
module tb_dmem_arbiter;

  localparam int NI  = 4;
  localparam int CYC = 400;
  localparam int NT  = 8;
  localparam logic Y = 1'b1;
  localparam logic N = 1'b0;
  localparam logic [31:0] R = 32'h12345678;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  always #5 clk = ~clk;

  logic [NI-1:0] req0, we0, req1, we1, gnt0, gnt1, rvalid0, rvalid1, mem_en, mem_we;
  logic [31:0] addr0[NI], wdata0[NI], addr1[NI], wdata1[NI];
  logic [31:0] rdata0[NI], rdata1[NI], mem_addr[NI], mem_wdata[NI], mem_rdata[NI];

  for (genvar g = 0; g < NI; g++) begin : gen_dut
    dmem_arbiter #(.READ_LAT(g + 1), .AW(32)) u_dut (
      .clk(clk), .reset_n(reset_n),
      .req0(req0[g]), .we0(we0[g]), .addr0(addr0[g]), .wdata0(wdata0[g]),
      .req1(req1[g]), .we1(we1[g]), .addr1(addr1[g]), .wdata1(wdata1[g]),
      .gnt0(gnt0[g]), .gnt1(gnt1[g]), .rvalid0(rvalid0[g]), .rvalid1(rvalid1[g]),
      .rdata0(rdata0[g]), .rdata1(rdata1[g]),
      .mem_en(mem_en[g]), .mem_we(mem_we[g]), .mem_addr(mem_addr[g]),
      .mem_wdata(mem_wdata[g]), .mem_rdata(mem_rdata[g])
    );
  end

  function automatic logic [31:0] init_word(int g, int i);
    if (i == 8) return R;
    return {16'hC0DE, 8'(g), 8'(i)};
  endfunction

  // Memory model: word-addressed store, read data appears READ_LAT cycles after the strobe.
  logic [31:0] mem [NI][256];
  logic [31:0] pipe [NI][4];
  logic mem_ready = 1'b0;
  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int g = 0; g < NI; g++)
        for (int i = 0; i < 256; i++) mem[g][i] <= init_word(g, i);
      mem_ready <= 1'b1;
    end else begin
      for (int g = 0; g < NI; g++)
        if (mem_en[g] && mem_we[g]) mem[g][mem_addr[g][9:2]] <= mem_wdata[g];
    end
    for (int g = 0; g < NI; g++) begin
      pipe[g][0] <= (mem_en[g] && !mem_we[g]) ? mem[g][mem_addr[g][9:2]] : 32'hA5A5_0000;
      for (int k = 1; k < 4; k++) pipe[g][k] <= pipe[g][k-1];
    end
  end
  always_comb begin
    for (int g = 0; g < NI; g++) mem_rdata[g] = pipe[g][g];
  end

  int nchk = 0;
  int nerr = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ctl(int g);
    return {26'd0, gnt0[g], gnt1[g], rvalid0[g], rvalid1[g], mem_en[g], mem_we[g]};
  endfunction

  task automatic clr_inputs();
    req0 = '0; we0 = '0; req1 = '0; we1 = '0;
    for (int g = 0; g < NI; g++) begin
      addr0[g] = '0; wdata0[g] = '0; addr1[g] = '0; wdata1[g] = '0;
    end
  endtask

  task automatic edge_drive();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    edge_drive();
    clr_inputs();
    reset_n = 1'b0;
    edge_drive();
    edge_drive();
    reset_n = 1'b1;
  endtask

  // Directed vectors for instance 0 (READ_LAT=1); ectl = {gnt0,gnt1,rv0,rv1,mem_en,mem_we}.
  typedef struct {
    logic r0, w0; logic [31:0] a0, d0;
    logic r1, w1; logic [31:0] a1, d1;
    logic [5:0] ectl;
    logic ca; logic [31:0] ea, ed, er0, er1;
  } vec_t;
  vec_t tbl[$];

  // Reference model output, one entry per cycle of a randomized run.
  typedef struct { logic we; logic [31:0] addr, wdata; int gap; } txn_t;
  logic [31:0] smem [NI][256];
  logic        p_req [2][CYC];
  logic        p_we  [2][CYC];
  logic [31:0] p_addr[2][CYC], p_wdata[2][CYC];
  logic        e_gnt [2][CYC], e_rv[2][CYC], e_en[CYC], e_we[CYC];
  logic [31:0] e_addr[CYC], e_wdata[CYC], e_rd[2][CYC];

  // Each requester holds its request until granted; ties go to the one not served last;
  // a write occupies the port for 2 cycles, a read for READ_LAT+3 with rvalid at +READ_LAT+2.
  task automatic plan(input int g);
    txn_t q[2][NT];
    txn_t t;
    int idx[2], gap[2], last, free_at, lat, w;
    logic pend[2];
    lat = g + 1; last = 1; free_at = 0;
    for (int c = 0; c < CYC; c++) begin
      e_en[c] = 0; e_we[c] = 0; e_addr[c] = 0; e_wdata[c] = 0;
      for (int r = 0; r < 2; r++) begin
        e_gnt[r][c] = 0; e_rv[r][c] = 0; e_rd[r][c] = 0;
        p_req[r][c] = 0; p_we[r][c] = 0; p_addr[r][c] = 0; p_wdata[r][c] = 0;
      end
    end
    for (int r = 0; r < 2; r++) begin
      idx[r] = 0; pend[r] = 0; gap[r] = int'($urandom_range(0, 2));
      for (int i = 0; i < NT; i++) begin
        q[r][i].we    = 1'($urandom_range(0, 1));
        q[r][i].addr  = 32'h80 + 32'($urandom_range(0, 63));
        q[r][i].wdata = $urandom;
        q[r][i].gap   = int'($urandom_range(0, 3));
      end
    end
    for (int c = 0; c < CYC - 8; c++) begin
      for (int r = 0; r < 2; r++) begin
        if (!pend[r] && idx[r] < NT) begin
          if (gap[r] == 0) pend[r] = 1;
          else gap[r]--;
        end
        p_req[r][c] = pend[r];
        if (idx[r] < NT) begin
          p_we[r][c] = q[r][idx[r]].we; p_addr[r][c] = q[r][idx[r]].addr;
          p_wdata[r][c] = q[r][idx[r]].wdata;
        end
      end
      if (c >= free_at && (pend[0] || pend[1])) begin
        w = (pend[0] && pend[1]) ? 1 - last : (pend[0] ? 0 : 1);
        last = w;
        t = q[w][idx[w]];
        e_gnt[w][c] = 1;
        e_en[c+1] = 1; e_we[c+1] = t.we; e_addr[c+1] = t.addr; e_wdata[c+1] = t.wdata;
        if (t.we) begin
          smem[g][t.addr[9:2]] = t.wdata;
          free_at = c + 2;
        end else begin
          e_rv[w][c+lat+2] = 1;
          e_rd[w][c+lat+2] = smem[g][t.addr[9:2]];
          free_at = c + lat + 3;
        end
        pend[w] = 0; idx[w]++; gap[w] = t.gap;
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, k;
    logic gseen;
    logic [31:0] ectl;
    for (int g = 0; g < NI; g++)
      for (int i = 0; i < 256; i++) smem[g][i] = init_word(g, i);

    tbl.push_back('{Y,Y,32'h10,32'hDEADBEEF, N,N,32'h0,32'h0, 6'b100000, N,32'h0,32'h0, 32'h0,32'h0});
    tbl.push_back('{N,N,32'h0,32'h0, N,N,32'h0,32'h0, 6'b000011, Y,32'h10,32'hDEADBEEF, 32'h0,32'h0});
    tbl.push_back('{N,N,32'h0,32'h0, N,N,32'h0,32'h0, 6'b000000, N,32'h0,32'h0, 32'h0,32'h0});
    tbl.push_back('{N,N,32'h0,32'h0, Y,N,32'h20,32'h0, 6'b010000, N,32'h0,32'h0, 32'h0,32'h0});
    tbl.push_back('{N,N,32'h0,32'h0, N,N,32'h0,32'h0, 6'b000010, Y,32'h20,32'h0, 32'h0,32'h0});
    tbl.push_back('{N,N,32'h0,32'h0, N,N,32'h0,32'h0, 6'b000000, N,32'h0,32'h0, 32'h0,32'h0});
    tbl.push_back('{N,N,32'h0,32'h0, N,N,32'h0,32'h0, 6'b000100, N,32'h0,32'h0, 32'h0,R});
    tbl.push_back('{N,N,32'h0,32'h0, N,N,32'h0,32'h0, 6'b000000, N,32'h0,32'h0, 32'h0,R});
    tbl.push_back('{Y,Y,32'h40,32'h1, Y,Y,32'h44,32'h2, 6'b100000, N,32'h0,32'h0, 32'h0,R});
    tbl.push_back('{N,N,32'h0,32'h0, Y,Y,32'h44,32'h2, 6'b000011, Y,32'h40,32'h1, 32'h0,R});
    tbl.push_back('{N,N,32'h0,32'h0, Y,Y,32'h44,32'h2, 6'b010000, N,32'h0,32'h0, 32'h0,R});
    tbl.push_back('{N,N,32'h0,32'h0, N,N,32'h0,32'h0, 6'b000011, Y,32'h44,32'h2, 32'h0,R});
    tbl.push_back('{Y,N,32'h20,32'h0, Y,N,32'h24,32'h0, 6'b100000, N,32'h0,32'h0, 32'h0,R});
    tbl.push_back('{N,N,32'h0,32'h0, Y,N,32'h24,32'h0, 6'b000010, Y,32'h20,32'h0, 32'h0,R});
    tbl.push_back('{N,N,32'h0,32'h0, Y,N,32'h24,32'h0, 6'b000000, N,32'h0,32'h0, 32'h0,R});
    tbl.push_back('{N,N,32'h0,32'h0, Y,N,32'h24,32'h0, 6'b001000, N,32'h0,32'h0, R,R});
    tbl.push_back('{N,N,32'h0,32'h0, Y,N,32'h24,32'h0, 6'b010000, N,32'h0,32'h0, R,R});
    tbl.push_back('{N,N,32'h0,32'h0, N,N,32'h0,32'h0, 6'b000010, Y,32'h24,32'h0, R,R});
    tbl.push_back('{N,N,32'h0,32'h0, N,N,32'h0,32'h0, 6'b000000, N,32'h0,32'h0, R,R});
    tbl.push_back('{N,N,32'h0,32'h0, N,N,32'h0,32'h0, 6'b000100, N,32'h0,32'h0, R,32'hC0DE0009});
    tbl.push_back('{N,N,32'h0,32'h0, N,N,32'h0,32'h0, 6'b000000, N,32'h0,32'h0, R,32'hC0DE0009});

    // Reset state, checked while reset_n is low.
    #1;
    clr_inputs();
    reset_n = 1'b0;
    #2;
    for (int g = 0; g < NI; g++) begin
      chk($sformatf("rst%0d_ctl", g), ctl(g), 32'h0);
      chk($sformatf("rst%0d_rdata0", g), rdata0[g], 32'h0);
      chk($sformatf("rst%0d_rdata1", g), rdata1[g], 32'h0);
      chk($sformatf("rst%0d_maddr", g), mem_addr[g], 32'h0);
      chk($sformatf("rst%0d_mwdata", g), mem_wdata[g], 32'h0);
    end
    edge_drive();
    edge_drive();
    reset_n = 1'b1;

    // Table-driven single write, single read, tie-breaking, hold-while-busy.
    foreach (tbl[i]) begin
      edge_drive();
      req0[0] = tbl[i].r0; we0[0] = tbl[i].w0; addr0[0] = tbl[i].a0; wdata0[0] = tbl[i].d0;
      req1[0] = tbl[i].r1; we1[0] = tbl[i].w1; addr1[0] = tbl[i].a1; wdata1[0] = tbl[i].d1;
      @(negedge clk);
      chk($sformatf("tbl%0d_ctl", i), ctl(0), {26'd0, tbl[i].ectl});
      chk($sformatf("tbl%0d_rdata0", i), rdata0[0], tbl[i].er0);
      chk($sformatf("tbl%0d_rdata1", i), rdata1[0], tbl[i].er1);
      if (tbl[i].ca) begin
        chk($sformatf("tbl%0d_maddr", i), mem_addr[0], tbl[i].ea);
        chk($sformatf("tbl%0d_mwdata", i), mem_wdata[0], tbl[i].ed);
      end
    end

    // Contention on instance 1 (READ_LAT=2): both reads held, grants every 5 cycles alternating.
    edge_drive();
    clr_inputs();
    req0[1] = 1'b1; addr0[1] = 32'h80; req1[1] = 1'b1; addr1[1] = 32'h84;
    for (int c = 0; c < 20; c++) begin
      if (c > 0) edge_drive();
      @(negedge clk);
      ectl = (c % 5 != 0) ? 32'd0 : (((c / 5) % 2 == 0) ? 32'd2 : 32'd1);
      chk($sformatf("cont_c%0d_gnt", c), {30'd0, gnt0[1], gnt1[1]}, ectl);
    end
    edge_drive();
    clr_inputs();

    // Latency sweep: grant-to-rvalid equals READ_LAT+2.
    do_reset();
    for (int g = 0; g < NI; g++) begin
      edge_drive();
      req0[g] = 1'b1; we0[g] = 1'b0; addr0[g] = 32'h20;
      @(negedge clk);
      chk($sformatf("sweep%0d_gnt", g), {31'd0, gnt0[g]}, 32'd1);
      lat = -1;
      for (int n = 1; n <= 12 && lat < 0; n++) begin
        edge_drive();
        req0[g] = 1'b0;
        @(negedge clk);
        if (rvalid0[g]) lat = n;
      end
      chk($sformatf("sweep%0d_lat", g), 32'(lat), 32'(g + 3));
      chk($sformatf("sweep%0d_rdata0", g), rdata0[g], R);
    end

    // Reset during WAIT on instance 2 (READ_LAT=3).
    edge_drive();
    req0[2] = 1'b1; we0[2] = 1'b0; addr0[2] = 32'h28;
    @(negedge clk);
    chk("abort_gnt", {31'd0, gnt0[2]}, 32'd1);
    edge_drive();
    req0[2] = 1'b0;
    edge_drive();
    reset_n = 1'b0;
    #1;
    chk("abort_ctl", ctl(2), 32'h0);
    chk("abort_maddr", mem_addr[2], 32'h0);
    chk("abort_mwdata", mem_wdata[2], 32'h0);
    chk("abort_rdata0", rdata0[2], 32'h0);
    edge_drive();
    reset_n = 1'b1;
    req0[2] = 1'b1; we0[2] = 1'b1; addr0[2] = 32'h50; wdata0[2] = 32'h5A5A5A5A;
    @(negedge clk);
    chk("abort_regnt", {31'd0, gnt0[2]}, 32'd1);
    for (int c = 1; c <= 8; c++) begin
      edge_drive();
      req0[2] = 1'b0;
      @(negedge clk);
      chk($sformatf("abort_c%0d_ctl", c), ctl(2), (c == 1) ? 32'h3 : 32'h0);
      if (c == 1) chk("abort_wdata", mem_wdata[2], 32'h5A5A5A5A);
    end

    // Back-to-back writes on instance 3: strobe every other cycle, data in order.
    edge_drive();
    req0[3] = 1'b1; we0[3] = 1'b1; addr0[3] = 32'h100; wdata0[3] = 32'hB000_0000;
    k = 0; gseen = 1'b0;
    for (int c = 0; c < 12; c++) begin
      if (c > 0) begin
        edge_drive();
        if (gseen) begin
          k++;
          addr0[3] = 32'h100 + 32'(4 * k);
          wdata0[3] = 32'hB000_0000 + 32'(k);
        end
      end
      @(negedge clk);
      gseen = gnt0[3];
      chk($sformatf("b2b_c%0d_ctl", c), ctl(3), (c % 2 == 0) ? 32'h20 : 32'h3);
      if (c % 2 == 1) begin
        chk($sformatf("b2b_c%0d_wdata", c), mem_wdata[3], 32'hB000_0000 + 32'((c - 1) / 2));
        chk($sformatf("b2b_c%0d_addr", c), mem_addr[3], 32'h100 + 32'(4 * ((c - 1) / 2)));
      end
    end
    edge_drive();
    clr_inputs();

    // Randomized traffic against the reference model, every latency.
    for (int g = 0; g < NI; g++) begin
      do_reset();
      plan(g);
      for (int c = 0; c < CYC; c++) begin
        edge_drive();
        req0[g] = p_req[0][c]; we0[g] = p_we[0][c]; addr0[g] = p_addr[0][c]; wdata0[g] = p_wdata[0][c];
        req1[g] = p_req[1][c]; we1[g] = p_we[1][c]; addr1[g] = p_addr[1][c]; wdata1[g] = p_wdata[1][c];
        @(negedge clk);
        chk($sformatf("rnd%0d_c%0d_ctl", g, c), ctl(g),
            {26'd0, e_gnt[0][c], e_gnt[1][c], e_rv[0][c], e_rv[1][c], e_en[c], e_we[c]});
        if (e_en[c]) chk($sformatf("rnd%0d_c%0d_maddr", g, c), mem_addr[g], e_addr[c]);
        if (e_en[c] && e_we[c]) chk($sformatf("rnd%0d_c%0d_mwdata", g, c), mem_wdata[g], e_wdata[c]);
        if (e_rv[0][c]) chk($sformatf("rnd%0d_c%0d_rdata0", g, c), rdata0[g], e_rd[0][c]);
        if (e_rv[1][c]) chk($sformatf("rnd%0d_c%0d_rdata1", g, c), rdata1[g], e_rd[1][c]);
      end
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
